// File: rtl/shift_bus_master.sv
// Sequences one shift request over the shifter register bus: ctrl write, operand write,
// a timed start/compute hold, then a result read whose value is returned on the response channel.
//
// state   | meaning
// IDLE    | accepting a request, bus quiet
// WR_CTRL | writing {dir, amount} to the ctrl register
// WR_DATA | writing the captured operand
// START   | holding start for WAIT_CYCLES cycles
// READ    | reading the result register, sampled at the end of the cycle
// RESP    | presenting the result until the consumer accepts it
module shift_bus_master #(
  parameter int unsigned WAIT_CYCLES = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_dir,
  input  logic [3:0]  req_amount,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic [1:0]  reg_sel,
  output logic        cs,
  output logic        we,
  output logic [15:0] bus_wdata,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_CTRL = 3'd1,
    WR_DATA = 3'd2,
    START   = 3'd3,
    READ    = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] SEL_CTRL   = 2'b00;
  localparam logic [1:0] SEL_DATA   = 2'b01;
  localparam logic [1:0] SEL_START  = 2'b11;
  localparam logic [1:0] SEL_RESULT = 2'b10;

  // Counter runs down to zero inclusive, so load one less than the hold length.
  localparam logic [7:0] START_LOAD = 8'(WAIT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic        cap_dir;
  logic [3:0]  cap_amount;
  logic [15:0] cap_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      cap_dir    <= 1'b0;
      cap_amount <= 4'd0;
      cap_data   <= 16'd0;
      resp_data  <= 16'd0;
    end else begin
      state <= state_next;
      if (state == IDLE && req_valid) begin
        cap_dir    <= req_dir;
        cap_amount <= req_amount;
        cap_data   <= req_data;
      end
      if (state == WR_DATA) begin
        cnt <= START_LOAD;
      end else if (state == START && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (state == READ) begin
        resp_data <= bus_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = WR_CTRL;
      WR_CTRL: state_next = WR_DATA;
      WR_DATA: state_next = START;
      START:   if (cnt == 8'd0) state_next = READ;
      READ:    state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    cs         = 1'b0;
    we         = 1'b0;
    reg_sel    = SEL_CTRL;
    bus_wdata  = 16'd0;
    case (state)
      IDLE: req_ready = 1'b1;
      WR_CTRL: begin
        cs        = 1'b1;
        we        = 1'b1;
        reg_sel   = SEL_CTRL;
        bus_wdata = {11'd0, cap_dir, cap_amount};
      end
      WR_DATA: begin
        cs        = 1'b1;
        we        = 1'b1;
        reg_sel   = SEL_DATA;
        bus_wdata = cap_data;
      end
      START: begin
        cs      = 1'b1;
        reg_sel = SEL_START;
      end
      READ: begin
        cs      = 1'b1;
        reg_sel = SEL_RESULT;
      end
      RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_shift_bus_master.sv
// Randomized bench for shift_bus_master: a bus-level shifter device model answers result reads,
// and every cycle of every transaction is compared against a request-level reference.
module tb_shift_bus_master;

  localparam int W = 5;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_dir;
  logic [3:0]  req_amount;
  logic [15:0] req_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic [1:0]  reg_sel;
  logic        cs;
  logic        we;
  logic [15:0] bus_wdata;
  logic [15:0] bus_rdata;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] last_result = 16'd0;

  shift_bus_master #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_dir(req_dir),
    .req_amount(req_amount), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .reg_sel(reg_sel), .cs(cs), .we(we), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shifter device: latches ctrl/operand writes; drives noise whenever it is not being read.
  logic [15:0] sh_ctrl = 16'd0;
  logic [15:0] sh_op = 16'd0;
  logic [15:0] noise = 16'hA5A5;
  always @(posedge clk) begin
    if (cs && we && reg_sel == 2'b00) sh_ctrl <= bus_wdata;
    if (cs && we && reg_sel == 2'b01) sh_op <= bus_wdata;
  end
  always @(negedge clk) noise <= 16'($urandom);
  assign bus_rdata = (cs && !we && reg_sel == 2'b10) ?
                     (sh_ctrl[4] ? (sh_op >> sh_ctrl[3:0]) : (sh_op << sh_ctrl[3:0])) : noise;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_shift(input logic dir, input logic [3:0] amt,
                                            input logic [15:0] data);
    int unsigned scale = 1;
    for (int i = 0; i < amt; i++) scale = scale * 2;
    if (dir) return 16'(int'(data) / scale);
    return 16'((int'(data) * scale) % 65536);
  endfunction

  // Starts and ends at a negedge with the DUT idle.
  task automatic run_req(input logic dir, input logic [3:0] amt, input logic [15:0] data,
                         input int bp, input bit busy_pulse);
    logic [15:0] exp_res;
    logic [19:0] exp_bus;
    exp_res = ref_shift(dir, amt, data);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_dir = dir; req_amount = amt; req_data = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_dir = ~dir; req_amount = 4'($urandom); req_data = 16'($urandom);
    for (int k = 1; k <= 3 + W; k++) begin
      if (k == 1)      exp_bus = {1'b1, 1'b1, 2'b00, 11'd0, dir, amt};
      else if (k == 2) exp_bus = {1'b1, 1'b1, 2'b01, data};
      else if (k <= 2 + W) exp_bus = {1'b1, 1'b0, 2'b11, 16'd0};
      else exp_bus = 20'd0;
      if (k <= 2 + W) check($sformatf("bus_step%0d", k), {cs, we, reg_sel, bus_wdata}, exp_bus);
      else check("bus_read", {cs, we, reg_sel}, 4'b1010);
      check("resp_valid_busy", resp_valid, 0);
      check("req_ready_busy", req_ready, 0);
      check("resp_data_hold", resp_data, last_result);
      if (busy_pulse && k == 4) begin
        req_valid = 1'b1; req_data = 16'hFFFF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int b = 0; b <= bp; b++) begin
      check("resp_valid", resp_valid, 1);
      check("resp_data", resp_data, exp_res);
      check("req_ready_resp", req_ready, 0);
      check("bus_resp", {cs, we, reg_sel}, 0);
      if (b == bp) resp_ready = 1'b1;
      @(negedge clk);
    end
    resp_ready = 1'b0;
    check("resp_valid_after", resp_valid, 0);
    check("req_ready_after", req_ready, 1);
    check("bus_idle", {cs, we, reg_sel, bus_wdata}, 0);
    last_result = exp_res;
  endtask

  task automatic reset_mid_start(input logic [15:0] data);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_dir = 1'b0; req_amount = 4'd3; req_data = data;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("in_start", {cs, we, reg_sel}, 4'b1011);
    reset = 1'b1;
    #1;
    check("rst_bus", {cs, we, reg_sel, bus_wdata}, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_data", resp_data, 0);
    check("rst_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    last_result = 16'd0;
    for (int i = 0; i < 12; i++) begin
      check("post_rst_quiet", {cs, we, reg_sel, resp_valid}, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_dir = 1'b0; req_amount = 4'd0;
    req_data = 16'd0; resp_ready = 1'b0;
    #2;
    check("reset_bus", {cs, we, reg_sel, bus_wdata}, 0);
    check("reset_resp", {resp_valid, resp_data}, 0);
    check("reset_req_ready", req_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    run_req(1'b0, 4'd1, 16'h0002, 3, 1'b0);
    run_req(1'b1, 4'd15, 16'h8000, 0, 1'b1);
    run_req(1'b0, 4'd2, 16'h0003, 0, 1'b0);
    run_req(1'b1, 4'd4, 16'h00F0, 0, 1'b0);
    reset_mid_start(16'h1234);
    run_req(1'b0, 4'd0, 16'h1234, 1, 1'b0);
    run_req(1'b1, 4'd0, 16'hBEEF, 0, 1'b0);

    for (int t = 0; t < 30; t++) begin
      run_req(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shift_bus_master.md
SHIFT_BUS_MASTER -- requirements
Module: shift_bus_master

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 5, number of cycles reg_sel=11 (start/compute) is held before the result read; legal range 1..255.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  shift request present.
REQ-005 SHALL have port req_ready  output  1  master idle and accepting a request.
REQ-006 SHALL have port req_dir  input  1  shift direction: 0 left, 1 right.
REQ-007 SHALL have port req_amount  input  4  shift amount, 0..15.
REQ-008 SHALL have port req_data  input  16  operand to shift.
REQ-009 SHALL have port resp_valid  output  1  result available.
REQ-010 SHALL have port resp_ready  input  1  consumer accepts result.
REQ-011 SHALL have port resp_data  output  16  shifted result.
REQ-012 SHALL have port reg_sel  output  2  shifter register select (00 ctrl, 01 operand, 11 start, 10 result).
REQ-013 SHALL have port cs  output  1  shifter chip select.
REQ-014 SHALL have port we  output  1  shifter write enable.
REQ-015 SHALL have port bus_wdata  output  16  to shifter data_in.
REQ-016 SHALL have port bus_rdata  input  16  from shifter data_out.

Function
REQ-017 SHALL implement states IDLE, WR_CTRL, WR_DATA, START, READ, RESP; bus outputs SHALL be a function of the state register only (Moore).
REQ-018 IDLE: req_ready=1, cs=0, we=0, reg_sel=00, bus_wdata=0; on req_valid=1, capture req_dir, req_amount, req_data and go to WR_CTRL.
REQ-019 req_ready SHALL be 1 only in IDLE; req_valid in any other state is ignored and not queued.
REQ-020 WR_CTRL (1 cycle): cs=1, we=1, reg_sel=00, bus_wdata={11'b0, dir, amount[3:0]}; then WR_DATA.
REQ-021 WR_DATA (1 cycle): cs=1, we=1, reg_sel=01, bus_wdata=captured operand; then START.
REQ-022 START: cs=1, we=0, reg_sel=11, bus_wdata=0, held exactly WAIT_CYCLES cycles via an 8-bit down-counter loaded on entry; then READ.
REQ-023 READ (1 cycle): cs=1, we=0, reg_sel=10; bus_rdata SHALL be sampled into resp_data on the rising edge ending READ; then RESP.
REQ-024 RESP: cs=0, we=0, reg_sel=00, resp_valid=1, resp_data stable; on resp_ready=1 go to IDLE; resp_valid SHALL stay high until accepted.
REQ-025 Latency: with acceptance at edge E, resp_valid SHALL first be 1 in the cycle after edge E+3+WAIT_CYCLES (9 cycles after acceptance for default).
REQ-026 Back-to-back: a request presented with req_valid=1 in the cycle after RESP acceptance SHALL be accepted immediately (one IDLE cycle minimum between transactions).
REQ-027 req_amount=0 SHALL be forwarded unchanged (ctrl word = {dir,0000}); no special-casing.
REQ-028 resp_data SHALL change only on the READ sampling edge; bus_rdata outside READ SHALL be ignored.

Reset
REQ-029 Reset assertion SHALL immediately (asynchronously) force state IDLE, counter 0, cs=0, we=0, reg_sel=00, bus_wdata=0, resp_valid=0, resp_data=0, req_ready=1 after release.
REQ-030 Reset in any state (including mid-START) SHALL abandon the transaction with no further bus accesses and no response.

Verification
REQ-031 Left shift: req dir=0, amount=1, data=0x0002, shifter model returns 0x0004 -> bus sequence (00,we=1,0x0001),(01,we=1,0x0002),5x(11,we=0),(10,we=0); resp_data=0x0004 nine cycles after acceptance.
REQ-032 Right shift: dir=1, amount=15, data=0x8000, model returns 0x0001 -> ctrl write 0x001F; resp_data=0x0001.
REQ-033 Back-pressure: resp_ready low 3 cycles in RESP -> resp_valid and resp_data=0x0004 held stable, req_ready=0, cs=0 throughout.
REQ-034 Busy request: req_valid pulsed during START with data 0xFFFF -> ignored; captured operand and result unchanged.
REQ-035 Reset mid-START: assert reset during 3rd START cycle -> cs=0, we=0, resp_valid=0 immediately; no READ access; next request completes normally.
REQ-036 Back-to-back: two requests (0x0003 left 2, 0x00F0 right 4) -> results 0x000C then 0x000F, in order, with one IDLE cycle between.
